// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver, LSB first; optional even-parity frame bit under DESER_PARITY_EN.
// Latency: word valid the cycle after its last bit. A one-word holding register absorbs stalls; a completion into a full register is dropped and flags overrun.
module serial_deserializer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  din,
    input  logic                  din_en,
    input  logic                  align,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic                  overrun,
    output logic                  parity_err
);

`ifdef DESER_PARITY_EN
    localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
    localparam int FRAME_LEN = DATA_WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    logic [FRAME_LEN-1:0] sr_q;
    logic [FRAME_LEN-1:0] sr_shift;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_next;
    logic                 sample;
    logic                 frame_done;
    logic                 frame_good;
    logic                 hold_free;
    logic                 load;
    logic                 drop;

    always_comb begin
        sr_shift   = {din, sr_q[FRAME_LEN-1:1]};
        sample     = din_en & ~align;
        frame_done = sample && (cnt_q == LAST_BIT);
`ifdef DESER_PARITY_EN
        frame_good = ~^sr_shift;
`else
        frame_good = 1'b1;
`endif
        // A transfer in the completing cycle frees the register for the new word.
        hold_free  = ~dout_valid | dout_ready;
        load       = frame_done & frame_good & hold_free;
        drop       = frame_done & frame_good & ~hold_free;

        cnt_next = cnt_q;
        if (align) begin
            cnt_next = '0;
        end else if (sample) begin
            cnt_next = frame_done ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sr_q       <= '0;
            cnt_q      <= '0;
            busy       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            cnt_q <= cnt_next;
            busy  <= (cnt_next != '0);

            if (align) begin
                sr_q <= '0;
            end else if (sample) begin
                sr_q <= sr_shift;
            end

            if (load) begin
                dout       <= sr_shift[DATA_WIDTH-1:0];
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end

            if (align) begin
                overrun <= 1'b0;
            end else if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef DESER_PARITY_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= frame_done & ~frame_good;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: scoreboard of expected words checked at each output transfer.
module tb_serial_deserializer;
    localparam int W = 16;
`ifdef DESER_PARITY_EN
    localparam int F = W + 1;
`else
    localparam int F = W;
`endif

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         din = 1'b0;
    logic         din_en = 1'b0;
    logic         align = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];
    int xfer_cyc[$];

    serial_deserializer #(.DATA_WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .din(din), .din_en(din_en), .align(align),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (resetn && dout_valid && dout_ready) begin
            xfer_cyc.push_back(cyc);
            chk("sb_expected_word_present", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("sb_word", 32'(dout), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $error("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din    = b;
        din_en = 1'b1;
        tick();
        din_en = 1'b0;
    endtask

    function automatic logic [F-1:0] mk_frame(input logic [W-1:0] w);
`ifdef DESER_PARITY_EN
        return {^w, w};
`else
        return w;
`endif
    endfunction

    task automatic send_range(input logic [F-1:0] fr, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_bit(fr[i]);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        send_range(mk_frame(w), 0, F - 1);
    endtask

    initial begin
        logic [F-1:0] fr;
        int t0;

        // Reset state
        tick(); tick();
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        dout_ready = 1'b1;

        // Continuous stream
        exp_q.push_back(16'hA5C3);
        fr = mk_frame(16'hA5C3);
        send_range(fr, 0, 0);
        chk("stream_busy_mid", 32'(busy), 32'd1);
        send_range(fr, 1, F - 1);
        chk("stream_valid", 32'(dout_valid), 32'd1);
        chk("stream_dout", 32'(dout), 32'hA5C3);
        chk("stream_busy_idle", 32'(busy), 32'd0);
        tick();
        chk("stream_valid_one_cycle", 32'(dout_valid), 32'd0);

        exp_q.push_back(16'h3C5A);
        exp_q.push_back(16'hF00D);
        send_word(16'h3C5A);
        send_word(16'hF00D);
        tick();
        chk("b2b_spacing", 32'(xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[xfer_cyc.size()-2]), 32'(F));
        chk("b2b_no_overrun", 32'(overrun), 32'd0);

        // Backpressure and overrun
        dout_ready = 1'b0;
        exp_q.push_back(16'h1234);
        send_word(16'h1234);
        chk("bp_first_no_overrun", 32'(overrun), 32'd0);
        send_word(16'hBEEF);
        chk("bp_dout_held", 32'(dout), 32'h1234);
        chk("bp_valid_held", 32'(dout_valid), 32'd1);
        chk("bp_overrun", 32'(overrun), 32'd1);
        dout_ready = 1'b1;
        tick();
        chk("bp_drained", 32'(dout_valid), 32'd0);
        chk("bp_overrun_sticky", 32'(overrun), 32'd1);
        align = 1'b1;
        tick();
        align = 1'b0;
        chk("align_clears_overrun", 32'(overrun), 32'd0);

        // Same-cycle drain
        dout_ready = 1'b0;
        exp_q.push_back(16'h1234);
        send_word(16'h1234);
        exp_q.push_back(16'hBEEF);
        fr = mk_frame(16'hBEEF);
        send_range(fr, 0, F - 2);
        dout_ready = 1'b1;
        send_bit(fr[F-1]);
        dout_ready = 1'b0;
        chk("drain_dout", 32'(dout), 32'hBEEF);
        chk("drain_valid", 32'(dout_valid), 32'd1);
        chk("drain_overrun", 32'(overrun), 32'd0);
        dout_ready = 1'b1;
        tick();
        chk("drain_done", 32'(dout_valid), 32'd0);

        // Gaps and align
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        chk("gap_busy_partial", 32'(busy), 32'd1);
        din = 1'($urandom_range(0, 1));
        din_en = 1'b1;
        align = 1'b1;
        tick();
        din_en = 1'b0;
        align = 1'b0;
        chk("align_busy", 32'(busy), 32'd0);
        exp_q.push_back(16'h00FF);
        fr = mk_frame(16'h00FF);
        for (int i = 0; i < F; i++) begin
            if (i != 0) repeat ($urandom_range(1, 3)) tick();
            send_bit(fr[i]);
            if (i == 3) chk("gap_busy", 32'(busy), 32'd1);
        end
        chk("gap_valid", 32'(dout_valid), 32'd1);
        chk("gap_dout", 32'(dout), 32'h00FF);
        tick();

        // Reset mid-frame
        for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(0, 1)));
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_valid", 32'(dout_valid), 32'd0);
        exp_q.push_back(16'h8001);
        send_word(16'h8001);
        chk("rstmid_valid_new", 32'(dout_valid), 32'd1);
        chk("rstmid_dout", 32'(dout), 32'h8001);
        chk("rstmid_overrun", 32'(overrun), 32'd0);
        tick();

`ifdef DESER_PARITY_EN
        // Parity good then bad
        exp_q.push_back(16'h0001);
        fr = {1'b1, 16'h0001};
        send_range(fr, 0, F - 1);
        chk("par_ok_valid", 32'(dout_valid), 32'd1);
        chk("par_ok_err", 32'(parity_err), 32'd0);
        tick();
        fr = {1'b0, 16'h0001};
        send_range(fr, 0, F - 1);
        chk("par_bad_err", 32'(parity_err), 32'd1);
        chk("par_bad_valid", 32'(dout_valid), 32'd0);
        chk("par_bad_overrun", 32'(overrun), 32'd0);
        tick();
        chk("par_err_pulse", 32'(parity_err), 32'd0);
`endif

        repeat (3) tick();
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
